exec_sequencer: RTL
===================

# exec_sequencer

Execute-stage sequencer for the RV32IM core: accepts one decoded instruction plus its register operands from decode via a valid/ready handshake and drives the ALU's `enabled` strobe. It waits for the ALU's `completed`, captures `result`, and resolves jumps and branches into a fetch redirect. It then presents the finished instruction to memory/writeback through a second valid/ready handshake. It is the initiator side of the ALU's `enabled`/`completed`/`result` interface.

## Interface
- `EXEC_TIMEOUT`, default 16: cycles in WAIT without `alu_completed` before a fault. Only used with `EXEC_TIMEOUT_EN`.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `issue_valid`  in  1  decode has an instruction.
- `issue_ready`  out  1  sequencer can accept.
- `issue_instr`  in  `instructions`  decoded instruction (one-hot op flags, `pc`, `imm`, `rd`).
- `issue_reg`  in  `regvpair`  operand values `rs1`, `rs2`.
- `alu_enabled`  out  1  one-cycle launch strobe to ALU.
- `alu_instr`  out  `instructions`  held instruction to ALU.
- `alu_reg`  out  `regvpair`  held operands to ALU.
- `alu_completed`  in  1  ALU done.
- `alu_result`  in  32  ALU result.
- `exec_valid`  out  1  finished instruction available.
- `exec_ready`  in  1  downstream accepts.
- `exec_instr`  out  `instructions`  held instruction.
- `exec_result`  out  32  ALU result; for loads and stores this is the effective address.
- `exec_store_data`  out  32  held `rs2`.
- `exec_rd_write`  out  1  register writeback required.
- `exec_mem_read` / `exec_mem_write`  out  1 each  load / store.
- `redirect_valid`  out  1  fetch must redirect; asserted only while `exec_valid`.
- `redirect_pc`  out  32  redirect target.
- `exec_fault`  out  1  ALU timeout; asserted only while `exec_valid`.

## Operation
- States: IDLE, LAUNCH, WAIT, DONE (`exec_state_t`).
- IDLE:
  - `issue_ready`=1.
  - On `issue_valid`, register `issue_instr`/`issue_reg` and go to LAUNCH.
- LAUNCH:
  - `alu_enabled`=1 for exactly this cycle.
  - Go to WAIT unconditionally.
- WAIT:
  - On `alu_completed`, capture `alu_result`, compute the outputs below, and go to DONE.
- DONE:
  - `exec_valid`=1 and all `exec_*`/`redirect_*` outputs are stable.
  - On `exec_ready`, go to IDLE.
- The ALU's `completed` is sticky, so only its level in WAIT is meaningful. WAIT is always at least one cycle after the launch strobe.
- `alu_instr`/`alu_reg` come from the held registers and are stable from LAUNCH through DONE.
- `redirect_valid`/`redirect_pc`:
  - `jal`: redirect to `pc + imm`.
  - `jalr`: redirect to `(rs1 + imm) & ~1`.
  - Conditional branch with `alu_result[0]`=1: redirect to `pc + imm`.
  - Branch not taken: `redirect_valid`=0.
- Arithmetic is 32-bit, modulo 2^32; carries are discarded.
- `exec_rd_write`=1 for lui, auipc, jal, jalr, all OP/OP-IMM, and RV32M ops, provided `rd`≠0. Otherwise 0.
- Loads and stores: `exec_rd_write`=0; `exec_mem_read`/`exec_mem_write` set according to the op.
- fence, fence.i, ecall, ebreak: no writeback, no memory access, no redirect.
- `rst` (including mid-operation) puts the block in IDLE in the next cycle and discards the held instruction.
- Reset values:
  - `issue_ready`=1.
  - `alu_enabled`, `exec_valid`, `exec_rd_write`, `exec_mem_read`, `exec_mem_write`, `redirect_valid`, `exec_fault` = 0.
  - `exec_result`, `exec_store_data`, `redirect_pc` = 0.

## Timing
- Issue handshake at edge of cycle T, then `alu_enabled` in T+1, result captured at the end of T+2, `exec_valid` in T+3.
- Minimum 4 cycles per instruction; no overlap. `issue_ready`=0 outside IDLE.
- `exec_valid` holds with stable data until `exec_ready`.
- Back-to-back operation: `exec_ready` in the first DONE cycle returns to IDLE, so the next issue handshake can occur in the following cycle.
- All outputs are registered or decoded from state registers only; there is no combinational path from any input to any output.

## Configuration
- `EXEC_TIMEOUT_EN` defined:
  - A counter runs in WAIT. If it reaches `EXEC_TIMEOUT` without `alu_completed`, go to DONE with `exec_fault`=1, `exec_result`=0, `exec_rd_write`=0, `exec_mem_read`=0, `exec_mem_write`=0, `redirect_valid`=0.
  - The counter clears on entry to WAIT.
  - If `alu_completed` and the limit occur in the same cycle, completion wins.
- `EXEC_TIMEOUT_EN` undefined: WAIT waits indefinitely; `exec_fault` tied to 0; no counter logic.

## Structure
- `exec_state_t` enum goes in the shared `def.sv` alongside `instructions` and `regvpair`.
- One combinational sub-module, `branch_resolver`:
  - Inputs: held instruction, `rs1`, `alu_result`.
  - Outputs: `redirect_valid`, `redirect_pc`, `exec_rd_write`, `exec_mem_read`, `exec_mem_write`.
- The sequencer registers the `branch_resolver` outputs in WAIT.

## Test plan
- `addi` rd=5, rs1=7, imm=3, ALU model returns 10 one cycle after the strobe -> `alu_enabled` exactly 1 cycle; `exec_valid` at T+3; `exec_result`=10, `exec_rd_write`=1, `redirect_valid`=0.
- `beq` pc=0x100, imm=0x20; ALU returns 1, then a second run returns 0 -> first: `redirect_valid`=1, `redirect_pc`=0x120; second: `redirect_valid`=0, `exec_rd_write`=0.
- `jalr` rd=1, rs1=0x2003, imm=4, pc=0x40 -> `exec_result`=0x44, `redirect_pc`=0x2006, `exec_rd_write`=1.
- `sw` rs1=0x1000, imm=-4, rs2=0xDEADBEEF; `exec_ready` held low 5 cycles -> `exec_result`=0xFFC, `exec_store_data`=0xDEADBEEF, `exec_mem_write`=1; outputs stable all 5 cycles; `issue_ready`=0 throughout.
- `rst` asserted during WAIT -> next cycle IDLE, `issue_ready`=1, `exec_valid`=0; a later `alu_completed` is ignored.
- With `EXEC_TIMEOUT_EN`, `EXEC_TIMEOUT`=16, ALU never completes -> `exec_valid` with `exec_fault`=1 exactly 16 WAIT cycles after entering WAIT; `exec_result`=0.

Source files
------------

// File: rtl/exec_sequencer_pkg.sv
// Shared types for the execute-stage sequencer: instruction payload, operand pair, FSM states.
package exec_sequencer_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DONE
  } exec_state_t;

  // One-hot instruction class; the ALU refines the operation with funct3.
  typedef struct packed {
    logic lui;
    logic auipc;
    logic jal;
    logic jalr;
    logic branch;
    logic load;
    logic store;
    logic op_imm;
    logic op;
    logic muldiv;
    logic fence;
    logic fence_i;
    logic ecall;
    logic ebreak;
  } op_flags_t;

  typedef struct packed {
    op_flags_t         op;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
  } instructions;

  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } regvpair;

  function automatic logic writes_rd(input op_flags_t op);
    return op.lui | op.auipc | op.jal | op.jalr | op.op_imm | op.op | op.muldiv;
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Decode-issue, ALU and memory/writeback signals of the execute sequencer, bundled.
interface exec_sequencer_if;
  import exec_sequencer_pkg::*;

  logic            issue_valid;
  logic            issue_ready;
  instructions     issue_instr;
  regvpair         issue_reg;

  logic            alu_enabled;
  instructions     alu_instr;
  regvpair         alu_reg;
  logic            alu_completed;
  logic [XLEN-1:0] alu_result;

  logic            exec_valid;
  logic            exec_ready;
  instructions     exec_instr;
  logic [XLEN-1:0] exec_result;
  logic [XLEN-1:0] exec_store_data;
  logic            exec_rd_write;
  logic            exec_mem_read;
  logic            exec_mem_write;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            exec_fault;

  // Sequencer side.
  modport slave (
    input  issue_valid, issue_instr, issue_reg, alu_completed, alu_result, exec_ready,
    output issue_ready, alu_enabled, alu_instr, alu_reg,
           exec_valid, exec_instr, exec_result, exec_store_data, exec_rd_write,
           exec_mem_read, exec_mem_write, redirect_valid, redirect_pc, exec_fault
  );

  // Decode / ALU / writeback side.
  modport master (
    output issue_valid, issue_instr, issue_reg, alu_completed, alu_result, exec_ready,
    input  issue_ready, alu_enabled, alu_instr, alu_reg,
           exec_valid, exec_instr, exec_result, exec_store_data, exec_rd_write,
           exec_mem_read, exec_mem_write, redirect_valid, redirect_pc, exec_fault
  );

endinterface

// File: rtl/exec_sequencer_branch_resolver.sv
// Combinational resolution of fetch redirect, writeback and memory-access flags for the held instruction.
module branch_resolver
  import exec_sequencer_pkg::*;
(
  input  instructions     instr,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] alu_result,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            exec_rd_write,
  output logic            exec_mem_read,
  output logic            exec_mem_write
);

  logic [XLEN-1:0] pc_target;
  logic [XLEN-1:0] reg_sum;

  always_comb begin
    pc_target      = instr.pc + instr.imm;
    reg_sum        = rs1 + instr.imm;
    redirect_valid = instr.op.jal | instr.op.jalr | (instr.op.branch & alu_result[0]);
    redirect_pc    = instr.op.jalr ? {reg_sum[XLEN-1:1], 1'b0} : pc_target;
    exec_rd_write  = writes_rd(instr.op) && (instr.rd != '0);
    exec_mem_read  = instr.op.load;
    exec_mem_write = instr.op.store;
  end

  // Fields that only the ALU or later stages care about.
  logic unused_fields;
  assign unused_fields = ^{instr.funct3, instr.op.fence, instr.op.fence_i,
                           instr.op.ecall, instr.op.ebreak, alu_result[XLEN-1:1]};

endmodule

// File: rtl/exec_sequencer.sv
// Execute-stage sequencer: issue -> ALU launch -> wait for completion -> present to writeback.
// Optional ALU watchdog enabled by defining EXEC_TIMEOUT_EN.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int unsigned EXEC_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  exec_sequencer_if.slave bus
);

  exec_state_t     state;
  instructions     instr_q;
  regvpair         reg_q;
  logic            issue_ready_q;
  logic            alu_enabled_q;
  logic            exec_valid_q;
  logic [XLEN-1:0] exec_result_q;
  logic [XLEN-1:0] exec_store_data_q;
  logic            exec_rd_write_q;
  logic            exec_mem_read_q;
  logic            exec_mem_write_q;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic            res_redirect_valid;
  logic [XLEN-1:0] res_redirect_pc;
  logic            res_rd_write;
  logic            res_mem_read;
  logic            res_mem_write;

  branch_resolver u_branch_resolver (
    .instr          (instr_q),
    .rs1            (reg_q.rs1),
    .alu_result     (bus.alu_result),
    .redirect_valid (res_redirect_valid),
    .redirect_pc    (res_redirect_pc),
    .exec_rd_write  (res_rd_write),
    .exec_mem_read  (res_mem_read),
    .exec_mem_write (res_mem_write)
  );

`ifdef EXEC_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(EXEC_TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             exec_fault_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |EXEC_TIMEOUT;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      instr_q           <= '0;
      reg_q             <= '0;
      issue_ready_q     <= 1'b1;
      alu_enabled_q     <= 1'b0;
      exec_valid_q      <= 1'b0;
      exec_result_q     <= '0;
      exec_store_data_q <= '0;
      exec_rd_write_q   <= 1'b0;
      exec_mem_read_q   <= 1'b0;
      exec_mem_write_q  <= 1'b0;
      redirect_valid_q  <= 1'b0;
      redirect_pc_q     <= '0;
`ifdef EXEC_TIMEOUT_EN
      wait_cnt          <= '0;
      exec_fault_q      <= 1'b0;
`endif
    end else begin
      alu_enabled_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.issue_valid) begin
            instr_q       <= bus.issue_instr;
            reg_q         <= bus.issue_reg;
            issue_ready_q <= 1'b0;
            alu_enabled_q <= 1'b1;
            state         <= LAUNCH;
          end
        end
        LAUNCH: begin
`ifdef EXEC_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          // Completion is checked first so it wins over a same-cycle timeout.
          if (bus.alu_completed) begin
            exec_result_q     <= bus.alu_result;
            exec_store_data_q <= reg_q.rs2;
            exec_rd_write_q   <= res_rd_write;
            exec_mem_read_q   <= res_mem_read;
            exec_mem_write_q  <= res_mem_write;
            redirect_valid_q  <= res_redirect_valid;
            redirect_pc_q     <= res_redirect_pc;
            exec_valid_q      <= 1'b1;
            state             <= DONE;
          end
`ifdef EXEC_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(EXEC_TIMEOUT - 1)) begin
            exec_result_q     <= '0;
            exec_store_data_q <= reg_q.rs2;
            exec_rd_write_q   <= 1'b0;
            exec_mem_read_q   <= 1'b0;
            exec_mem_write_q  <= 1'b0;
            redirect_valid_q  <= 1'b0;
            exec_fault_q      <= 1'b1;
            exec_valid_q      <= 1'b1;
            state             <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        DONE: begin
          if (bus.exec_ready) begin
            exec_valid_q     <= 1'b0;
            redirect_valid_q <= 1'b0;
            issue_ready_q    <= 1'b1;
`ifdef EXEC_TIMEOUT_EN
            exec_fault_q     <= 1'b0;
`endif
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.issue_ready     = issue_ready_q;
  assign bus.alu_enabled     = alu_enabled_q;
  assign bus.alu_instr       = instr_q;
  assign bus.alu_reg         = reg_q;
  assign bus.exec_valid      = exec_valid_q;
  assign bus.exec_instr      = instr_q;
  assign bus.exec_result     = exec_result_q;
  assign bus.exec_store_data = exec_store_data_q;
  assign bus.exec_rd_write   = exec_rd_write_q;
  assign bus.exec_mem_read   = exec_mem_read_q;
  assign bus.exec_mem_write  = exec_mem_write_q;
  assign bus.redirect_valid  = redirect_valid_q;
  assign bus.redirect_pc     = redirect_pc_q;
`ifdef EXEC_TIMEOUT_EN
  assign bus.exec_fault      = exec_fault_q;
`else
  assign bus.exec_fault      = 1'b0;
`endif

endmodule
